// File: rtl/vend_sequencer.sv
// Credit-and-dispense controller: accumulates coin credit, vends at PRICE, then
// drives the dispenser and change hopper through req/ack handshakes with a timeout.
module vend_sequencer #(
    parameter int PRICE       = 15,
    parameter int MAX_CREDIT  = 30,
    parameter int CREDIT_W    = 6,
    parameter int ACK_TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [1:0]          coin,
    input  logic                cancel,
    output logic                disp_req,
    input  logic                disp_ack,
    output logic                pay_req,
    input  logic                pay_ack,
    output logic [CREDIT_W-1:0] credit,
    output logic                busy,
    output logic                coin_reject,
    output logic                fault
);

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_DISPENSE = 2'd1;
    localparam logic [1:0] ST_PAYOUT   = 2'd2;
    localparam logic [1:0] ST_FAULT    = 2'd3;

    localparam int TW = $clog2(ACK_TIMEOUT + 1);
    localparam int AW = CREDIT_W + 1;

    localparam logic [AW-1:0] PRICE_W = AW'(PRICE);
    localparam logic [AW-1:0] MAX_W   = AW'(MAX_CREDIT);
    localparam logic [AW-1:0] FIVE_W  = AW'(5);
    localparam logic [AW-1:0] TEN_W   = AW'(10);
    localparam logic [TW-1:0] TIMER_LAST = TW'(ACK_TIMEOUT - 1);

    logic [1:0]          state_reg, state_next;
    logic [CREDIT_W-1:0] credit_reg, credit_next;
    logic                disp_req_reg, disp_req_next;
    logic                pay_req_reg, pay_req_next;
    logic                coin_reject_reg, coin_reject_next;
    logic                fault_reg, fault_next;
    logic                busy_reg, busy_next;
    logic [TW-1:0]       timer_reg, timer_next;

    logic [AW-1:0] credit_ext;
    logic [AW-1:0] coin_val;
    logic [AW-1:0] sum;

    always_comb begin
        state_next       = state_reg;
        credit_next      = credit_reg;
        disp_req_next    = disp_req_reg;
        pay_req_next     = pay_req_reg;
        coin_reject_next = 1'b0;
        fault_next       = fault_reg;
        timer_next       = timer_reg;

        credit_ext = {1'b0, credit_reg};
        coin_val   = (coin == 2'b01) ? FIVE_W : (coin == 2'b10) ? TEN_W : '0;
        sum        = credit_ext + coin_val;

        case (state_reg)
            ST_IDLE: begin
                timer_next = '0;
                // Cancel takes precedence over a coin arriving in the same cycle.
                if (cancel) begin
                    coin_reject_next = (coin != 2'b00);
                    if (credit_reg != '0) begin
                        state_next   = ST_PAYOUT;
                        pay_req_next = 1'b1;
                    end
                end else if (coin == 2'b11) begin
                    coin_reject_next = 1'b1;
                end else if (coin != 2'b00) begin
                    if (sum > MAX_W) begin
                        coin_reject_next = 1'b1;
                    end else if (sum >= PRICE_W) begin
                        credit_next   = CREDIT_W'(sum - PRICE_W);
                        state_next    = ST_DISPENSE;
                        disp_req_next = 1'b1;
                    end else begin
                        credit_next = CREDIT_W'(sum);
                    end
                end
            end
            ST_DISPENSE: begin
                coin_reject_next = (coin != 2'b00);
                if (disp_ack) begin
                    disp_req_next = 1'b0;
                    timer_next    = '0;
                    if (credit_reg != '0) begin
                        state_next   = ST_PAYOUT;
                        pay_req_next = 1'b1;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end else if (timer_reg == TIMER_LAST) begin
                    state_next    = ST_FAULT;
                    disp_req_next = 1'b0;
                    fault_next    = 1'b1;
                    timer_next    = '0;
                end else begin
                    timer_next = timer_reg + TW'(1);
                end
            end
            ST_PAYOUT: begin
                coin_reject_next = (coin != 2'b00);
                // After each ack the request stays low one cycle before the next coin.
                if (!pay_req_reg) begin
                    pay_req_next = 1'b1;
                end else if (pay_ack) begin
                    credit_next  = CREDIT_W'(credit_ext - FIVE_W);
                    pay_req_next = 1'b0;
                    timer_next   = '0;
                    if (credit_ext == FIVE_W) begin
                        state_next = ST_IDLE;
                    end
                end else if (timer_reg == TIMER_LAST) begin
                    state_next   = ST_FAULT;
                    pay_req_next = 1'b0;
                    fault_next   = 1'b1;
                    timer_next   = '0;
                end else begin
                    timer_next = timer_reg + TW'(1);
                end
            end
            default: begin
                coin_reject_next = (coin != 2'b00);
                disp_req_next    = 1'b0;
                pay_req_next     = 1'b0;
                fault_next       = 1'b1;
                timer_next       = '0;
            end
        endcase

        busy_next = (state_next != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg       <= ST_IDLE;
            credit_reg      <= '0;
            disp_req_reg    <= 1'b0;
            pay_req_reg     <= 1'b0;
            coin_reject_reg <= 1'b0;
            fault_reg       <= 1'b0;
            busy_reg        <= 1'b0;
            timer_reg       <= '0;
        end else begin
            state_reg       <= state_next;
            credit_reg      <= credit_next;
            disp_req_reg    <= disp_req_next;
            pay_req_reg     <= pay_req_next;
            coin_reject_reg <= coin_reject_next;
            fault_reg       <= fault_next;
            busy_reg        <= busy_next;
            timer_reg       <= timer_next;
        end
    end

    assign disp_req    = disp_req_reg;
    assign pay_req     = pay_req_reg;
    assign credit      = credit_reg;
    assign busy        = busy_reg;
    assign coin_reject = coin_reject_reg;
    assign fault       = fault_reg;

endmodule
